// File: rtl/alu_pkg.sv
// Shared op-code encodings and FSM states for the multi-cycle ALU.
package alu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_MUL  = 4'h3;
    localparam logic [3:0] OP_DIV  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_SLL  = 4'h7;
    localparam logic [3:0] OP_SRL  = 4'h8;
    localparam logic [3:0] OP_ROL  = 4'h9;
    localparam logic [3:0] OP_ROR  = 4'hA;
    localparam logic [3:0] OP_NEG  = 4'hB;
    localparam logic [3:0] OP_XOR  = 4'hC;
    localparam logic [3:0] OP_NOR  = 4'hD;
    localparam logic [3:0] OP_NAND = 4'hE;
    localparam logic [3:0] OP_SRA  = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Unsigned iterative engine: WIDTH-step shift/add multiply or restoring divide.
// Result is {hi,lo}: product, or {remainder, quotient}.
module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_go,
    input  logic               i_is_div,
    input  logic [WIDTH-1:0]   i_mag_a,
    input  logic [WIDTH-1:0]   i_mag_b,
    output logic [2*WIDTH-1:0] o_res,
    output logic               o_last
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]    r_cnt;
    logic             r_act;
    logic             r_div;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_d;

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shl;
    logic [WIDTH:0] w_diff;

    // Multiply: conditionally add multiplicand into the upper half, then shift right.
    assign w_sum  = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_d : {WIDTH{1'b0}})};
    // Divide: shift next dividend bit into the partial remainder and trial-subtract.
    assign w_shl  = {r_hi, r_lo[WIDTH-1]};
    assign w_diff = w_shl - {1'b0, r_d};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_act <= 1'b0;
            r_cnt <= '0;
            r_div <= 1'b0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_d   <= '0;
        end else if (i_go) begin
            r_act <= 1'b1;
            r_cnt <= CW'(WIDTH - 1);
            r_div <= i_is_div;
            r_hi  <= '0;
            r_lo  <= i_mag_a;
            r_d   <= i_mag_b;
        end else if (r_act) begin
            if (r_div) begin
                r_hi <= w_diff[WIDTH] ? w_shl[WIDTH-1:0] : w_diff[WIDTH-1:0];
                r_lo <= {r_lo[WIDTH-2:0], ~w_diff[WIDTH]};
            end else begin
                {r_hi, r_lo} <= {w_sum, r_lo[WIDTH-1:1]};
            end
            if (r_cnt == '0)
                r_act <= 1'b0;
            else
                r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_res  = {r_hi, r_lo};
    assign o_last = r_act && (r_cnt == '0);

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/shift ops plus iterative signed MUL/DIV
// writing architectural HI/LO, with start/busy/done handshake.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t           r_state;
    logic             r_pend;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_neg_p;
    logic             r_neg_a;
    logic             r_fin;
    logic             r_fin_div;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic             r_dbz;

    logic               w_accept;
    logic               w_go;
    logic               w_is_div;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_res;
    logic               w_last;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_accept = start && (r_state == S_IDLE);
    assign w_is_div = (op == OP_DIV);
    // DIV by zero bypasses the engine and completes through the single-cycle path.
    assign w_go     = w_accept && ((op == OP_MUL) || (w_is_div && (B != '0)));
    assign w_mag_a  = A[WIDTH-1] ? -A : A;
    assign w_mag_b  = B[WIDTH-1] ? -B : B;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_go     (w_go),
        .i_is_div (w_is_div),
        .i_mag_a  (w_mag_a),
        .i_mag_b  (w_mag_b),
        .o_res    (w_res),
        .o_last   (w_last)
    );

    // Sign fix-up: remainder follows the dividend, quotient/product follow A^B.
    assign w_prod = r_neg_p ? -w_res : w_res;
    assign w_quo  = r_neg_p ? -w_res[WIDTH-1:0] : w_res[WIDTH-1:0];
    assign w_rem  = r_neg_a ? -w_res[2*WIDTH-1:WIDTH] : w_res[2*WIDTH-1:WIDTH];

    logic [SHW-1:0]   w_sh;
    logic [SHW:0]     w_rsh;
    logic             w_big;
    logic [SHW-1:0]   w_sra_amt;
    logic [WIDTH-1:0] w_sra;
    logic [WIDTH-1:0] w_sc;

    assign w_sh      = r_b[SHW-1:0];
    assign w_rsh     = (SHW+1)'(WIDTH) - {1'b0, w_sh};
    assign w_big     = |r_b[WIDTH-1:SHW];
    assign w_sra_amt = w_big ? SHW'(WIDTH - 1) : w_sh;
    assign w_sra     = $signed(r_a) >>> w_sra_amt;

    always_comb begin
        w_sc = r_lo;
        case (r_op)
            OP_ADD:  w_sc = r_a + r_b;
            OP_SUB:  w_sc = r_a - r_b;
            OP_AND:  w_sc = r_a & r_b;
            OP_OR:   w_sc = r_a | r_b;
            OP_SLL:  w_sc = w_big ? '0 : (r_a << w_sh);
            OP_SRL:  w_sc = w_big ? '0 : (r_a >> w_sh);
            OP_ROL:  w_sc = (r_a << w_sh) | (r_a >> w_rsh);
            OP_ROR:  w_sc = (r_a >> w_sh) | (r_a << w_rsh);
            OP_NEG:  w_sc = -r_b;
            OP_XOR:  w_sc = r_a ^ r_b;
            OP_NOR:  w_sc = ~(r_a | r_b);
            OP_NAND: w_sc = ~(r_a & r_b);
            OP_SRA:  w_sc = w_sra;
            default: w_sc = r_lo;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_pend    <= 1'b0;
            r_op      <= OP_NOP;
            r_a       <= '0;
            r_b       <= '0;
            r_neg_p   <= 1'b0;
            r_neg_a   <= 1'b0;
            r_fin     <= 1'b0;
            r_fin_div <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            r_pend <= 1'b0;
            r_fin  <= 1'b0;

            if (r_pend) begin
                r_done <= 1'b1;
                if (r_op == OP_DIV) begin
                    r_dbz <= 1'b1;
                    r_hi  <= r_a;
                    r_lo  <= '1;
                end else if (r_op != OP_NOP && r_op != OP_MUL) begin
                    r_lo <= w_sc;
                end
            end

            if (r_fin) begin
                r_done <= 1'b1;
                if (r_fin_div) begin
                    r_hi <= w_rem;
                    r_lo <= w_quo;
                end else begin
                    {r_hi, r_lo} <= w_prod;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_neg_p <= A[WIDTH-1] ^ B[WIDTH-1];
                        r_neg_a <= A[WIDTH-1];
                        if (w_go) begin
                            r_state <= w_is_div ? S_DIV : S_MUL;
                        end else begin
                            r_pend <= 1'b1;
                            r_op   <= op;
                            r_a    <= A;
                            r_b    <= B;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (w_last) begin
                        r_state   <= S_IDLE;
                        r_fin     <= 1'b1;
                        r_fin_div <= (r_state == S_DIV);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

// File: tb/tb_alu_mc.sv
// Randomized self-checking bench for alu_mc against a plain-arithmetic reference.
module tb_alu_mc;

    localparam int W = 32;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_chk;
    int n_fail;

    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;
    logic         m_dz;

    alu_mc #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .op          (op),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog timeout checks=%0d", n_chk);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: updates m_hi/m_lo/m_dz from signed arithmetic on the operands.
    task automatic ref_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint p, q, r;
        logic [W-1:0] x;
        int n;
        m_dz = 1'b0;
        case (o)
            4'h1: m_lo = a + b;
            4'h2: m_lo = a - b;
            4'h3: begin
                p = longint'($signed(a)) * longint'($signed(b));
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            4'h4: begin
                if (b == 0) begin
                    m_dz = 1'b1;
                    m_hi = a;
                    m_lo = '1;
                end else begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end
            end
            4'h5: m_lo = a & b;
            4'h6: m_lo = a | b;
            4'h7: m_lo = (b >= W) ? '0 : a << b;
            4'h8: m_lo = (b >= W) ? '0 : a >> b;
            4'h9, 4'hA: begin
                x = a;
                n = int'(b % W);
                for (int i = 0; i < n; i++)
                    x = (o == 4'h9) ? {x[W-2:0], x[W-1]} : {x[0], x[W-1:1]};
                m_lo = x;
            end
            4'hB: m_lo = -b;
            4'hC: m_lo = a ^ b;
            4'hD: m_lo = ~(a | b);
            4'hE: m_lo = ~(a & b);
            4'hF: m_lo = (b >= W) ? {W{a[W-1]}} : W'($signed(a) >>> b);
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit poke, input string tag);
        bit multi;
        bit ok;
        multi = (o == 4'h3) || (o == 4'h4 && b != 0);
        ref_op(o, a, b);
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0; A = $urandom; B = $urandom; op = 4'($urandom);
        if (multi) begin
            ok = 1'b1;
            for (int i = 0; i < W; i++) begin
                if (busy !== 1'b1 || done !== 1'b0) ok = 1'b0;
                start = poke;
                @(posedge clk); #1;
            end
            start = 1'b0;
            chk({tag, "_busywin"}, 64'(ok), 64'd1);
            chk({tag, "_busyend"}, {busy, done}, 2'b00);
        end else begin
            chk({tag, "_nobusy"}, {busy, done}, 2'b00);
        end
        @(posedge clk); #1;
        chk({tag, "_done"}, {done, div_by_zero}, {1'b1, m_dz});
        chk({tag, "_hilo"}, {hi, lo}, {m_hi, m_lo});
    endtask

    function automatic logic [W-1:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'($urandom_range(0, 9));
            3: return 32'($urandom_range(30, 40));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        logic [3:0] o;
        n_chk = 0; n_fail = 0;
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        reset_n = 1'b0; start = 1'b0; op = '0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", {busy, done, div_by_zero, hi, lo}, '0);
        @(negedge clk) reset_n = 1'b1;

        run_op(4'h1, 32'h7FFF_FFFF, 32'd1, 1'b0, "add_ovf");
        run_op(4'h3, -32'sd3, 32'd7, 1'b1, "mul_neg");
        run_op(4'h4, -32'sd7, 32'd2, 1'b1, "div_neg");
        run_op(4'h4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_min");
        run_op(4'h4, 32'd5, 32'd0, 1'b0, "div_zero");
        run_op(4'hF, 32'h8000_0000, 32'd40, 1'b0, "sra_big");
        run_op(4'h8, 32'h8000_0000, 32'd32, 1'b0, "srl_32");
        run_op(4'h9, 32'h8000_0001, 32'd33, 1'b0, "rol_33");
        run_op(4'hA, 32'h0000_0001, 32'd1, 1'b0, "ror_1");
        run_op(4'h0, 32'h1234_5678, 32'h9, 1'b0, "nop");

        // Reset in the middle of a multiply discards it.
        @(negedge clk);
        start = 1'b1; op = 4'h3; A = 32'd1000; B = 32'd1000;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_reset", {busy, done, hi, lo}, '0);
        m_hi = '0; m_lo = '0;
        @(negedge clk) reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_reset_quiet", {busy, done}, 2'b00);
        run_op(4'h1, 32'd2, 32'd3, 1'b0, "add_after_rst");

        for (int k = 0; k < 80; k++) begin
            o = 4'($urandom_range(0, 15));
            run_op(o, pick_val(), (o == 4'h4 && $urandom_range(0, 4) == 0) ? '0 : pick_val(),
                   1'($urandom), $sformatf("rnd%0d_op%0h", k, o));
        end

        @(posedge clk); #1;
        chk("idle_done_low", {busy, done, div_by_zero}, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Multi-cycle, width-parametrised successor to the single-cycle CPU ALU. Single-cycle logic/arithmetic ops complete in one cycle. Signed MUL and DIV run on an iterative shift/add-subtract engine instead of combinational arrays. Results land in architectural HI/LO registers, and a start/busy/done handshake tells the CPU control FSM when to stall.

Parameters:
WIDTH, 32, operand and HI/LO register width; must be ≥4 and a power of two.
SHW, $clog2(WIDTH), derived; bits of B used as rotate amount.

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  synchronous active-low reset
start  input  1  request; accepted only when busy=0
op  input  4  operation select, encoding below
A  input  WIDTH  signed operand A / dividend / shift source
B  input  WIDTH  signed operand B / divisor / shift amount
busy  output  1  high while MUL/DIV iterates
done  output  1  one-cycle pulse: HI/LO updated this cycle
div_by_zero  output  1  valid with done; set for DIV with B=0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (reset_n=0 at a clk edge, any state, including mid-MUL/DIV): state←IDLE; hi=lo=0; busy=0; done=0; div_by_zero=0. An in-flight op is discarded.
- Op encoding:
  - 0000 NOP: done pulses, HI/LO unchanged.
  - 0001 ADD, 0010 SUB: wrap modulo 2^WIDTH.
  - 0011 MUL, 0100 DIV.
  - 0101 AND, 0110 OR.
  - 0111 SLL, 1000 SRL, 1001 ROL, 1010 ROR.
  - 1011 NEG: LO = −B.
  - 1100 XOR, 1101 NOR, 1110 NAND.
  - 1111 SRA.
- Single-cycle ops: start accepted at edge N → LO written, done=1 at edge N+1. HI is retained. busy stays 0.
- Shift rules:
  - SLL/SRL: if unsigned B ≥ WIDTH, result 0.
  - SRA: if unsigned B ≥ WIDTH, result is all sign bits.
  - ROL/ROR: rotate by B[SHW-1:0]; amount 0 leaves A unchanged.
- FSM: IDLE, MUL, DIV.
  - IDLE + start + op=MUL → MUL. A and B are latched, so later input changes are ignored.
  - IDLE + start + op=DIV with B≠0 → DIV.
  - MUL/DIV run WIDTH iterations. Step counter runs WIDTH−1 down to 0; at 0 the next state is IDLE.
  - busy=1 exactly during the WIDTH cycles in MUL/DIV.
  - Result and done=1 appear at edge N+WIDTH+1.
- MUL: signed full product. HI = upper WIDTH bits, LO = lower WIDTH bits. Computed on magnitudes; sign applied at the end.
- DIV: signed, truncation toward zero. LO = quotient; HI = remainder, with the sign of the dividend. MIN/−1 gives LO = MIN, HI = 0 (two's-complement wrap, no trap).
- DIV with B=0: no iteration. At edge N+1: done=1, div_by_zero=1, HI=A, LO = all ones.
- done and div_by_zero are registered, one-cycle pulses; both are 0 whenever no completion occurs.
- start while busy=1 is ignored: no queueing and no error.
- start in the same cycle done=1 (FSM in IDLE) is accepted, giving back-to-back ops with no bubble.
- Unknown/X op never occurs; all 16 encodings are defined.

Decomposition:
- Package alu_pkg: op-code localparams (OP_NOP … OP_SRA), FSM state enum (S_IDLE, S_MUL, S_DIV).
- Sub-module alu_muldiv_iter:
  - Inputs: clk, reset_n, go, is_div, magnitude operands.
  - Outputs: WIDTH-cycle shift-add / restoring-divide datapath, 2·WIDTH result, last-step flag.
- alu_mc holds the FSM, sign fix-up, single-cycle datapath and HI/LO registers.

Test Plan:
- ADD, A=0x7FFFFFFF, B=1 → next cycle done=1, LO=0x80000000, HI unchanged (0 after reset).
- MUL, A=−3, B=7 → busy high for 32 cycles; done at cycle 33 with HI=0xFFFFFFFF, LO=0xFFFFFFEB. start pulses during busy are ignored.
- DIV, A=−7, B=2 → cycle 33: LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1), div_by_zero=0. Then DIV 0x80000000/−1 → LO=0x80000000, HI=0.
- DIV, A=5, B=0 → next cycle done=1, div_by_zero=1, HI=5, LO=0xFFFFFFFF, busy never rises.
- Shifts/rotates: SRA 0x80000000 by 40 → 0xFFFFFFFF; SRL by 32 → 0; ROL 0x80000001 by 33 → 0x00000003; ROR 0x00000001 by 1 → 0x80000000.
- reset_n=0 at cycle 10 of a MUL → next cycle busy=0, hi=lo=0, no done. A following ADD 2+3 completes normally with LO=5.
